// File: rtl/prime_generator.sv
// Sequential prime enumerator: walks candidates upward from start_val and streams the
// first `count` primes found by 6k+/-1 trial division over a valid/ready handshake.
module prime_generator #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic [WIDTH-1:0] prime_out,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TEST,
    S_EMIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    V_STEP,
    V_PRIME,
    V_COMPOSITE
  } verdict_t;

  localparam logic [WIDTH-1:0] CAND_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CAND_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CAND_TRI  = WIDTH'(3);
  localparam logic [WIDTH:0]   DIV_INIT  = (WIDTH+1)'(5);
  localparam logic [WIDTH:0]   DIV_STEP  = (WIDTH+1)'(6);
  localparam logic [WIDTH:0]   DIV_PAIR  = (WIDTH+1)'(2);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             state;
  state_t             state_next;
  verdict_t           verdict;

  logic [WIDTH-1:0]   cand;
  logic [WIDTH:0]     div;
  logic [CNT_W-1:0]   remaining;

  logic               load_req;
  logic               cand_advance;
  logic               div_step;
  logic               latch_prime;
  logic               set_overflow;
  logic               xfer;

  logic [WIDTH:0]     div_hi;
  logic [WIDTH:0]     cand_ext;
  logic [2*WIDTH+1:0] div_wide;
  logic [2*WIDTH+1:0] div_sq;
  logic [2*WIDTH+1:0] cand_wide;
  logic [WIDTH-1:0]   cand_mod3;
  logic [WIDTH:0]     rem_lo;
  logic [WIDTH:0]     rem_hi;

  // Divisor arithmetic is one bit wider than the candidate and the square is
  // taken at double width, so neither the 6k+1 partner nor div*div can wrap.
  assign div_hi    = div + DIV_PAIR;
  assign cand_ext  = {1'b0, cand};
  assign div_wide  = {{(WIDTH+1){1'b0}}, div};
  assign div_sq    = div_wide * div_wide;
  assign cand_wide = {{(WIDTH+2){1'b0}}, cand};
  assign cand_mod3 = cand % CAND_TRI;
  assign rem_lo    = cand_ext % div;
  assign rem_hi    = cand_ext % div_hi;

  always_comb begin
    verdict = V_STEP;
    if (cand <= CAND_ONE) begin
      verdict = V_COMPOSITE;
    end else if (cand <= CAND_TRI) begin
      verdict = V_PRIME;
    end else if (!cand[0] || (cand_mod3 == '0)) begin
      verdict = V_COMPOSITE;
    end else if (div_sq > cand_wide) begin
      verdict = V_PRIME;
    end else if ((rem_lo == '0) || (rem_hi == '0)) begin
      verdict = V_COMPOSITE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    load_req     = 1'b0;
    cand_advance = 1'b0;
    div_step     = 1'b0;
    latch_prime  = 1'b0;
    set_overflow = 1'b0;
    xfer         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_req   = 1'b1;
          state_next = (count == CNT_ZERO) ? S_DONE : S_TEST;
        end
      end
      S_TEST: begin
        case (verdict)
          V_PRIME: begin
            latch_prime = 1'b1;
            state_next  = S_EMIT;
          end
          V_COMPOSITE: begin
            if (cand == CAND_MAX) begin
              set_overflow = 1'b1;
              state_next   = S_DONE;
            end else begin
              cand_advance = 1'b1;
            end
          end
          default: div_step = 1'b1;
        endcase
      end
      S_EMIT: begin
        if (prime_ready) begin
          xfer = 1'b1;
          if (remaining == CNT_ONE) begin
            state_next = S_DONE;
          end else if (cand == CAND_MAX) begin
            set_overflow = 1'b1;
            state_next   = S_DONE;
          end else begin
            cand_advance = 1'b1;
            state_next   = S_TEST;
          end
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      prime_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy        <= (state_next != S_IDLE);
      prime_valid <= (state_next == S_EMIT);
      done        <= (state_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= '0;
      div       <= '0;
      remaining <= '0;
      prime_out <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load_req) begin
        cand      <= start_val;
        remaining <= count;
        div       <= DIV_INIT;
        overflow  <= 1'b0;
      end
      if (cand_advance) begin
        cand <= cand + CAND_ONE;
        div  <= DIV_INIT;
      end
      if (div_step) begin
        div <= div + DIV_STEP;
      end
      if (latch_prime) begin
        prime_out <= cand;
      end
      if (set_overflow) begin
        overflow <= 1'b1;
      end
      if (xfer) begin
        remaining <= remaining - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_prime_generator.sv
// Self-checking bench for prime_generator: a 32-bit and an 8-bit instance driven by
// directed and randomized requests, compared against a plain trial-division model.
module tb_prime_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start32;
  logic [31:0] sv32;
  logic [15:0] cnt32;
  logic        busy32;
  logic [31:0] po32;
  logic        pv32;
  logic        pr32;
  logic        done32;
  logic        ovf32;

  logic        start8;
  logic [7:0]  sv8;
  logic [7:0]  cnt8;
  logic        busy8;
  logic [7:0]  po8;
  logic        pv8;
  logic        pr8;
  logic        done8;
  logic        ovf8;

  prime_generator #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start32), .start_val(sv32), .count(cnt32),
    .busy(busy32), .prime_out(po32), .prime_valid(pv32), .prime_ready(pr32),
    .done(done32), .overflow(ovf32)
  );

  prime_generator #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .start_val(sv8), .count(cnt8),
    .busy(busy8), .prime_out(po8), .prime_valid(pv8), .prime_ready(pr8),
    .done(done8), .overflow(ovf8)
  );

  int total  = 0;
  int passed = 0;

  longint exp_q[$];
  bit     exp_ovf;

  longint cap_q[$];
  int     cap_idx_q[$];
  int     cap_first_idx;
  int     cap_done_cnt;
  int     cap_done_idx;
  int     cap_stable_err;
  bit     cap_busy_after;
  bit     cap_done_after;
  bit     cap_ovf;
  bit     cap_timeout;

  function automatic bit model_is_prime(longint n);
    if (n < 2) return 1'b0;
    for (longint d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference: the first cnt primes >= sval that fit below the width limit.
  task automatic model_expect(input longint sval, input int cnt, input longint maxv);
    longint p;
    exp_q.delete();
    p = sval;
    while (exp_q.size() < cnt && p <= maxv) begin
      if (model_is_prime(p)) exp_q.push_back(p);
      p++;
    end
    exp_ovf = (exp_q.size() < cnt);
  endtask

  // Issues one request and records what the selected instance emits; no checking here.
  task automatic run_request(input bit use8, input longint sval, input int cnt,
                             input int ready_pct, input int hold, input bit poke);
    bit     v, b, d, o, rdy, prev_stall, seen_done;
    longint po, prev_out;
    int     held;
    cap_q.delete();
    cap_idx_q.delete();
    cap_first_idx  = -1;
    cap_done_cnt   = 0;
    cap_done_idx   = -1;
    cap_stable_err = 0;
    cap_busy_after = 1'b1;
    cap_done_after = 1'b1;
    cap_ovf        = 1'b0;
    cap_timeout    = 1'b1;
    @(negedge clk);
    if (use8) begin
      start8 = 1'b1; sv8 = sval[7:0]; cnt8 = cnt[7:0];
    end else begin
      start32 = 1'b1; sv32 = sval[31:0]; cnt32 = cnt[15:0];
    end
    @(negedge clk);
    start8 = 1'b0;
    start32 = 1'b0;
    prev_stall = 1'b0;
    prev_out = 0;
    seen_done = 1'b0;
    held = 0;
    for (int idx = 0; idx < 20000; idx++) begin
      if (idx > 0) @(negedge clk);
      if (use8) begin
        v = pv8; b = busy8; d = done8; o = ovf8; po = longint'(po8);
      end else begin
        v = pv32; b = busy32; d = done32; o = ovf32; po = longint'(po32);
      end
      start8 = 1'b0;
      start32 = 1'b0;
      if (seen_done) begin
        cap_busy_after = b;
        cap_done_after = d;
        cap_ovf = o;
        cap_timeout = 1'b0;
        break;
      end
      if (prev_stall && (!v || po != prev_out)) cap_stable_err++;
      if (d) begin
        cap_done_cnt++;
        cap_done_idx = idx;
        seen_done = 1'b1;
      end
      if (held < hold) rdy = 1'b0;
      else rdy = ($urandom_range(99) < ready_pct);
      if (v && held < hold) held++;
      if (use8) pr8 = rdy;
      else pr32 = rdy;
      if (v && cap_first_idx < 0) cap_first_idx = idx;
      if (v && rdy) begin
        cap_q.push_back(po);
        cap_idx_q.push_back(idx);
      end
      prev_stall = v && !rdy;
      prev_out = po;
      if (poke && idx == 3 && b) begin
        if (use8) begin
          start8 = 1'b1; sv8 = 8'd100; cnt8 = 8'd7;
        end else begin
          start32 = 1'b1; sv32 = 32'd500; cnt32 = 16'd7;
        end
      end
    end
    pr8 = 1'b0;
    pr32 = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({busy32, pv32, done32, ovf32, po32} !== 36'd0) begin
      $display("[TB] FAIL reset32 outputs got %h want 0", {busy32, pv32, done32, ovf32, po32});
    end else passed++;
    total++;
    if ({busy8, pv8, done8, ovf8, po8} !== 12'd0) begin
      $display("[TB] FAIL reset8 outputs got %h want 0", {busy8, pv8, done8, ovf8, po8});
    end else passed++;
  endtask

  task automatic test_small_primes();
    run_request(1'b0, 0, 5, 100, 0, 1'b1);
    model_expect(0, 5, 64'hFFFF_FFFF);
    total++;
    if (cap_q.size() != exp_q.size()) begin
      $display("[TB] FAIL small_count got %0d want %0d", cap_q.size(), exp_q.size());
    end else passed++;
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      total++;
      if (cap_q[i] !== exp_q[i]) begin
        $display("[TB] FAIL small_prime[%0d] got %0d want %0d", i, cap_q[i], exp_q[i]);
      end else passed++;
    end
    total++;
    if (cap_done_cnt != 1 || cap_done_after !== 1'b0) begin
      $display("[TB] FAIL small_done pulses got %0d/%0b want 1/0", cap_done_cnt, cap_done_after);
    end else passed++;
    total++;
    if (cap_ovf !== 1'b0 || cap_busy_after !== 1'b0) begin
      $display("[TB] FAIL small_tail ovf/busy got %0b/%0b want 0/0", cap_ovf, cap_busy_after);
    end else passed++;
  endtask

  task automatic test_rejects();
    run_request(1'b0, 24, 2, 100, 0, 1'b0);
    total++;
    if (cap_q.size() != 2) begin
      $display("[TB] FAIL reject_count got %0d want 2", cap_q.size());
    end else passed++;
    total++;
    if (cap_q.size() == 2 && (cap_q[0] !== 29 || cap_q[1] !== 31)) begin
      $display("[TB] FAIL reject_primes got %0d,%0d want 29,31", cap_q[0], cap_q[1]);
    end else if (cap_q.size() == 2) passed++;
    else $display("[TB] FAIL reject_primes got short stream want 29,31");
  endtask

  task automatic test_hold();
    run_request(1'b0, 97, 1, 100, 10, 1'b0);
    total++;
    if (cap_q.size() != 1 || cap_q[0] !== 97) begin
      $display("[TB] FAIL hold_prime got %0d items first %0d want 1 item 97",
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : -1);
    end else passed++;
    total++;
    if (cap_stable_err != 0) begin
      $display("[TB] FAIL hold_stable got %0d glitches want 0", cap_stable_err);
    end else passed++;
    total++;
    if (cap_done_cnt != 1 || cap_busy_after !== 1'b0) begin
      $display("[TB] FAIL hold_done got %0d/%0b want 1/0", cap_done_cnt, cap_busy_after);
    end else passed++;
  endtask

  task automatic test_zero_count();
    run_request(1'b0, 40, 0, 100, 0, 1'b0);
    total++;
    if (cap_first_idx != -1) begin
      $display("[TB] FAIL zero_valid got valid at %0d want none", cap_first_idx);
    end else passed++;
    total++;
    if (cap_done_cnt != 1 || cap_done_idx < 0 || cap_done_idx > 1) begin
      $display("[TB] FAIL zero_done got %0d pulses at %0d want 1 at <=1", cap_done_cnt, cap_done_idx);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    run_request(1'b0, 2, 4, 100, 0, 1'b0);
    total++;
    if (cap_first_idx != 1) begin
      $display("[TB] FAIL b2b_latency got %0d want 1", cap_first_idx);
    end else passed++;
    total++;
    if (cap_idx_q.size() < 2 || cap_idx_q[1] - cap_idx_q[0] != 2) begin
      $display("[TB] FAIL b2b_spacing got %0d transfers want spacing 2", cap_idx_q.size());
    end else passed++;
    total++;
    if (cap_q.size() != 4 || cap_q[3] !== 7) begin
      $display("[TB] FAIL b2b_stream got %0d items want 4 ending in 7", cap_q.size());
    end else passed++;
  endtask

  task automatic test_overflow();
    run_request(1'b1, 250, 3, 100, 0, 1'b0);
    total++;
    if (cap_q.size() != 1 || cap_q[0] !== 251) begin
      $display("[TB] FAIL ovf_stream got %0d items want only 251", cap_q.size());
    end else passed++;
    total++;
    if (cap_ovf !== 1'b1 || cap_done_cnt != 1) begin
      $display("[TB] FAIL ovf_flag got %0b/%0d want 1/1", cap_ovf, cap_done_cnt);
    end else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (ovf8 !== 1'b1) begin
      $display("[TB] FAIL ovf_hold got %0b want 1", ovf8);
    end else passed++;
  endtask

  task automatic test_random();
    longint sval;
    int     cnt;
    bit     use8;
    for (int r = 0; r < 14; r++) begin
      use8 = (r >= 8);
      sval = use8 ? longint'($urandom_range(255, 200)) : longint'($urandom_range(5000));
      cnt  = use8 ? int'($urandom_range(5, 1)) : int'($urandom_range(4, 1));
      run_request(use8, sval, cnt, 50, 0, 1'b0);
      model_expect(sval, cnt, use8 ? 255 : 64'hFFFF_FFFF);
      total++;
      if (cap_timeout || cap_q.size() != exp_q.size()) begin
        $display("[TB] FAIL rand%0d_count start %0d got %0d want %0d", r, sval, cap_q.size(), exp_q.size());
      end else passed++;
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
        total++;
        if (cap_q[i] !== exp_q[i]) begin
          $display("[TB] FAIL rand%0d_prime[%0d] got %0d want %0d", r, i, cap_q[i], exp_q[i]);
        end else passed++;
      end
      total++;
      if (cap_ovf !== exp_ovf || cap_stable_err != 0 || cap_done_cnt != 1) begin
        $display("[TB] FAIL rand%0d_status ovf %0b glitches %0d done %0d want ovf %0b 0 1",
                 r, cap_ovf, cap_stable_err, cap_done_cnt, exp_ovf);
      end else passed++;
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start32 = 1'b1; sv32 = 32'd1000003; cnt32 = 16'd1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (busy32 !== 1'b1 || pv32 !== 1'b0) begin
      $display("[TB] FAIL abort_busy got %0b/%0b want 1/0", busy32, pv32);
    end else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy32, pv32, done32, ovf32, po32} !== 36'd0 || {busy8, pv8, done8, ovf8, po8} !== 12'd0) begin
      $display("[TB] FAIL abort_outputs got %h/%h want 0/0",
               {busy32, pv32, done32, ovf32, po32}, {busy8, pv8, done8, ovf8, po8});
    end else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_request(1'b0, 10, 1, 100, 0, 1'b0);
    total++;
    if (cap_q.size() != 1 || cap_q[0] !== 11 || cap_done_cnt != 1) begin
      $display("[TB] FAIL abort_restart got %0d items first %0d want 1 item 11",
               cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : -1);
    end else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    start32 = 1'b0; sv32 = '0; cnt32 = '0; pr32 = 1'b0;
    start8 = 1'b0;  sv8 = '0;  cnt8 = '0;  pr8 = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_small_primes();
    test_rejects();
    test_hold();
    test_zero_count();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
